// File: rtl/taxi_lfsr_prbs_mon.sv
// taxi_lfsr_prbs_mon: self-synchronising PRBS checker with SEARCH/LOCKED tracking and BER counters; TAXI_PRBS_MON_STATS_EN adds word_cnt/err_word_cnt
module taxi_lfsr_prbs_mon #(
  parameter int LFSR_W = 31,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 31'h10000001,
  parameter logic [LFSR_W-1:0] LFSR_INIT = '1,
  parameter bit REVERSE = 1'b0,
  parameter bit INVERT = 1'b1,
  parameter int DATA_W = 32,
  parameter int LOCK_CNT = 16,
  parameter int WIN_LEN = 256,
  parameter int UNLOCK_ERR = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] err_out,
  output logic              err_valid,
  output logic              locked,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [CNT_W-1:0]  lock_loss_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_word_cnt
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  localparam int PW = $clog2(DATA_W + 1);
  localparam int SW = (CNT_W > PW ? CNT_W : PW) + 1;
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [DATA_W-1:0] rx, mask;
  logic [GW-1:0] good_cnt, good_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [EW-1:0] win_err, werr_n;
  logic word_err, upd, loss;
  logic [PW-1:0] pop;
  logic [SW-1:0] bit_sum;
  function automatic logic [PW-1:0] popcount(input logic [DATA_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < DATA_W; i++) popcount = popcount + PW'(v[i]);
  endfunction
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + 1'b1 : c;
  endfunction
  assign rx = data_in ^ {DATA_W{INVERT}};
  // Fibonacci feed-forward: the shift register is loaded with received bits, not predictions
  always_comb begin
    lfsr_n = lfsr;
    mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[REVERSE ? i : DATA_W-1-i] = rx[REVERSE ? i : DATA_W-1-i] ^ lfsr_n[LFSR_W-1] ^
                                       ^(lfsr_n[LFSR_W-2:0] & LFSR_POLY[LFSR_W-1:1]);
      lfsr_n = {lfsr_n[LFSR_W-2:0], rx[REVERSE ? i : DATA_W-1-i]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_INIT;
      err_out <= '0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= data_in_valid;
      lfsr <= data_in_valid ? lfsr_n : lfsr;
      err_out <= data_in_valid ? mask : err_out;
    end
  end
  assign word_err = |err_out;
  assign upd = err_valid && state == LOCKED;
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    good_n = good_cnt;
    win_n = win_cnt;
    werr_n = win_err;
    loss = 1'b0;
    if (err_valid && state == SEARCH) begin
      good_n = word_err ? '0 : good_cnt + 1'b1;
      if (!word_err && good_cnt == GW'(LOCK_CNT - 1)) begin
        state_n = LOCKED;
        good_n = '0;
        win_n = '0;
        werr_n = '0;
      end
    end else if (upd) begin
      win_n = win_cnt + 1'b1;
      werr_n = win_err + EW'(word_err);
      if (werr_n == EW'(UNLOCK_ERR)) begin
        state_n = SEARCH;
        good_n = '0;
        loss = 1'b1;
      end else if (win_n == WW'(WIN_LEN)) begin
        win_n = '0;
        werr_n = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEARCH;
      good_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
    end else begin
      state <= state_n;
      good_cnt <= good_n;
      win_cnt <= win_n;
      win_err <= werr_n;
    end
  end
  assign pop = popcount(err_out);
  assign bit_sum = SW'(bit_err_cnt) + SW'(pop);
  // clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_err_cnt <= '0;
      lock_loss_cnt <= '0;
    end else begin
      bit_err_cnt <= upd ? (|bit_sum[SW-1:CNT_W] ? '1 : bit_sum[CNT_W-1:0]) : bit_err_cnt;
      lock_loss_cnt <= sat_inc(lock_loss_cnt, loss);
    end
  end
`ifdef TAXI_PRBS_MON_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_cnt <= '0;
      err_word_cnt <= '0;
    end else begin
      word_cnt <= sat_inc(word_cnt, upd);
      err_word_cnt <= sat_inc(err_word_cnt, upd && word_err);
    end
  end
`else
  assign word_cnt = '0;
  assign err_word_cnt = '0;
`endif
endmodule

// File: tb/tb_taxi_lfsr_prbs_mon.sv
// tb_taxi_lfsr_prbs_mon: PRBS31 stream bench with a history-based reference checker and scenario table
module tb_taxi_lfsr_prbs_mon;
  localparam int DW = 32;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam int BIG = 1 << 30;
`ifdef TAXI_PRBS_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {
    string name;
    int words, lead, n_bad, stride, period, flip;
    bit gap, clr, exp_locked;
    int exp_bit, exp_loss, exp_sbit, exp_words;
  } scen_t;
  logic clk = 1'b0, rst = 1'b1, data_in_valid = 1'b0, clear = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] err_out, s_eo;
  logic err_valid, locked, s_ev, s_locked;
  logic [31:0] bit_err_cnt, lock_loss_cnt, word_cnt, err_word_cnt;
  logic [3:0] s_bit, s_loss, s_word, s_errw;
  int checks = 0, errors = 0;
  bit txq[$], rxq[$];
  logic [DW-1:0] m_eo;
  bit m_ev, m_locked;
  int m_good, m_win, m_werr;
  longint m_bit[2], m_loss[2], m_words[2], m_errw[2];
  longint cmax[2] = '{MAX32, 15};
  always #5 clk = ~clk;
  taxi_lfsr_prbs_mon dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid), .clear(clear),
    .err_out(err_out), .err_valid(err_valid), .locked(locked), .bit_err_cnt(bit_err_cnt),
    .lock_loss_cnt(lock_loss_cnt), .word_cnt(word_cnt), .err_word_cnt(err_word_cnt)
  );
  taxi_lfsr_prbs_mon #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid), .clear(clear),
    .err_out(s_eo), .err_valid(s_ev), .locked(s_locked), .bit_err_cnt(s_bit),
    .lock_loss_cnt(s_loss), .word_cnt(s_word), .err_word_cnt(s_errw)
  );
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic longint sat(input longint v, input longint a, input longint mx);
    return (v + a > mx) ? mx : v + a;
  endfunction
  // transmitter: s[n] = s[n-28] ^ s[n-31], MSB first, sent inverted
  function automatic logic [DW-1:0] next_tx();
    logic [DW-1:0] w;
    bit b;
    for (int i = DW - 1; i >= 0; i--) begin
      b = txq[3] ^ txq[0];
      txq.push_back(b);
      void'(txq.pop_front());
      w[i] = b;
    end
    return ~w;
  endfunction
  function automatic logic [DW-1:0] model_mask(input logic [DW-1:0] d);
    logic [DW-1:0] m;
    bit r;
    for (int i = DW - 1; i >= 0; i--) begin
      r = ~d[i];
      m[i] = r ^ rxq[3] ^ rxq[0];
      rxq.push_back(r);
      void'(rxq.pop_front());
    end
    return m;
  endfunction
  function automatic void model_reset();
    rxq.delete();
    repeat (31) rxq.push_back(1'b1);
    m_eo = '0; m_ev = 0; m_locked = 0; m_good = 0; m_win = 0; m_werr = 0;
    for (int j = 0; j < 2; j++) begin
      m_bit[j] = 0; m_loss[j] = 0; m_words[j] = 0; m_errw[j] = 0;
    end
  endfunction
  function automatic void model_clock(input logic [DW-1:0] d, input bit v, input bit clr);
    bit e;
    int pc;
    e = m_eo != 0;
    pc = $countones(m_eo);
    if (m_ev && m_locked) begin
      for (int j = 0; j < 2; j++) begin
        m_bit[j] = sat(m_bit[j], pc, cmax[j]);
        m_words[j] = sat(m_words[j], 1, cmax[j]);
        m_errw[j] = sat(m_errw[j], longint'(e), cmax[j]);
      end
      m_win++;
      m_werr += int'(e);
      if (m_werr == 8) begin
        m_locked = 0;
        m_good = 0;
        for (int j = 0; j < 2; j++) m_loss[j] = sat(m_loss[j], 1, cmax[j]);
      end else if (m_win == 256) begin
        m_win = 0;
        m_werr = 0;
      end
    end else if (m_ev) begin
      m_good = e ? 0 : m_good + 1;
      if (m_good == 16) begin
        m_locked = 1; m_good = 0; m_win = 0; m_werr = 0;
      end
    end
    if (clr)
      for (int j = 0; j < 2; j++) begin
        m_bit[j] = 0; m_loss[j] = 0; m_words[j] = 0; m_errw[j] = 0;
      end
    if (v) m_eo = model_mask(d);
    m_ev = v;
  endfunction
  task automatic compare_all();
    chk("err_valid", longint'(err_valid), longint'(m_ev));
    chk("err_out", longint'(err_out), longint'(m_eo));
    chk("locked", longint'(locked), longint'(m_locked));
    chk("bit_err_cnt", longint'(bit_err_cnt), m_bit[0]);
    chk("lock_loss_cnt", longint'(lock_loss_cnt), m_loss[0]);
    chk("word_cnt", longint'(word_cnt), STATS ? m_words[0] : 0);
    chk("err_word_cnt", longint'(err_word_cnt), STATS ? m_errw[0] : 0);
    chk("w4.err_out", longint'(s_eo), longint'(m_eo));
    chk("w4.locked", longint'(s_locked), longint'(m_locked));
    chk("w4.bit_err_cnt", longint'(s_bit), m_bit[1]);
    chk("w4.lock_loss_cnt", longint'(s_loss), m_loss[1]);
    chk("w4.word_cnt", longint'(s_word), STATS ? m_words[1] : 0);
    chk("w4.err_word_cnt", longint'(s_errw), STATS ? m_errw[1] : 0);
  endtask
  task automatic tick(input logic [DW-1:0] d, input bit v, input bit clr);
    data_in = d;
    data_in_valid = v;
    clear = clr;
    @(posedge clk);
    model_clock(d, v, clr);
    #1;
    compare_all();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    data_in_valid = 1'b0;
    clear = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    compare_all();
    chk("rst.locked", longint'(locked), 0);
    chk("rst.err_valid", longint'(err_valid), 0);
    chk("rst.err_out", longint'(err_out), 0);
    chk("rst.bit_err_cnt", longint'(bit_err_cnt), 0);
    chk("rst.lock_loss_cnt", longint'(lock_loss_cnt), 0);
  endtask
  initial begin
    scen_t sc[8];
    logic [DW-1:0] d;
    bit v;
    int k, fb;
    sc[0] = '{"lock",          20,   0, 0,  1, BIG,  0, 0, 0, 1,  0, 0,  0, -1};
    sc[1] = '{"single_flip",   300, 10, 1,  1, BIG,  5, 0, 1, 1,  3, 0,  3, -1};
    sc[2] = '{"unlock",        72,   0, 8, 10, BIG, 31, 0, 1, 0, 24, 1, 15, -1};
    sc[3] = '{"relock",        20,   0, 0,  1, BIG,  0, 0, 0, 1, 24, 1, 15, -1};
    sc[4] = '{"seven_per_win", 1024, 0, 7, 30, 256, 31, 0, 1, 1, 84, 0, 15, -1};
    sc[5] = '{"gaps",          60,   0, 0,  1, BIG,  0, 1, 1, 1,  0, 0,  0, 20};
    sc[6] = '{"sat4",          300, 280, 6, 3, BIG, 31, 0, 1, 1, 18, 0, 15, -1};
    sc[7] = '{"flush",         300,  0, 0,  1, BIG,  0, 0, 0, 1, 18, 0, 15, -1};
    txq.push_back(1'b1);
    repeat (30) txq.push_back(1'($urandom_range(0, 1)));
    do_reset();
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < sc[s].words; i++) begin
        v = !sc[s].gap || (i % 3 == 0);
        d = v ? next_tx() : DW'($urandom());
        k = i - sc[s].lead;
        if (v && k >= 0 && (k % sc[s].period) % sc[s].stride == 0 &&
            (k % sc[s].period) / sc[s].stride < sc[s].n_bad)
          d[sc[s].flip] ^= 1'b1;
        tick(d, v, sc[s].clr && i == 0);
      end
      chk({sc[s].name, ".locked"}, longint'(locked), longint'(sc[s].exp_locked));
      chk({sc[s].name, ".bit_err_cnt"}, longint'(bit_err_cnt), sc[s].exp_bit);
      chk({sc[s].name, ".lock_loss_cnt"}, longint'(lock_loss_cnt), sc[s].exp_loss);
      chk({sc[s].name, ".w4.bit_err_cnt"}, longint'(s_bit), sc[s].exp_sbit);
      if (sc[s].exp_words >= 0)
        chk({sc[s].name, ".word_cnt"}, longint'(word_cnt), STATS ? sc[s].exp_words : 0);
    end
    // clear lands on the same edge as the errored word's increment
    tick(next_tx() ^ 32'h8000_0000, 1'b1, 1'b0);
    tick(next_tx(), 1'b1, 1'b1);
    chk("clr_prio.w4.bit_err_cnt", longint'(s_bit), 0);
    chk("clr_prio.bit_err_cnt", longint'(bit_err_cnt), 0);
    tick(next_tx() ^ 32'h8000_0000, 1'b1, 1'b0);
    tick(next_tx(), 1'b1, 1'b0);
    chk("after_clr.w4.bit_err_cnt", longint'(s_bit), 3);
    chk("after_clr.locked", longint'(locked), 1);
    do_reset();
    repeat (20) tick(next_tx(), 1'b1, 1'b0);
    chk("rst_relock.locked", longint'(locked), 1);
    chk("rst_relock.lock_loss_cnt", longint'(lock_loss_cnt), 0);
    repeat (2000) begin
      v = $urandom_range(0, 3) != 0;
      d = v ? next_tx() : DW'($urandom());
      if ($urandom_range(0, 49) == 0) begin
        fb = $urandom_range(0, DW - 1);
        d[fb] ^= 1'b1;
      end
      tick(d, v, $urandom_range(0, 199) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
